// File: rtl/ftoi_seq_pkg.sv
// Shared constants, state encoding and result helpers for the sequential
// float-to-int32 converter.
package ftoi_seq_pkg;

  localparam logic [7:0]  BIAS         = 8'd127;
  localparam logic [7:0]  EXP_INT_BASE = 8'd150;
  localparam logic [7:0]  EXP_OVF      = 8'd158;
  localparam logic [7:0]  EXP_MAX      = 8'd255;
  localparam logic [31:0] NEG_MAX      = 32'h8000_0000;
  localparam logic [31:0] POS_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] X_NEG_2P31   = 32'hCF00_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SMALL  = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_OVF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_e;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
    logic        nx;
  } result_t;

  function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
    logic [31:0] res;
    if (neg) begin
      res = ~mag + 32'd1;
    end else begin
      res = mag;
    end
    return res;
  endfunction

  // Results for operands that never enter the shifter.
  function automatic result_t special_result(input cls_e cls, input logic [31:0] x);
    result_t r;
    r.y   = 32'd0;
    r.ovf = 1'b0;
    r.nx  = 1'b0;
    case (cls)
      CLS_ZERO: begin
        r.nx = |x[22:0];
      end
      CLS_SMALL: begin
        r.nx = 1'b1;
      end
      CLS_NAN: begin
        r.y   = POS_MAX;
        r.ovf = 1'b1;
      end
      CLS_OVF: begin
        if (x == X_NEG_2P31) begin
          r.y   = NEG_MAX;
          r.ovf = 1'b0;
        end else begin
          r.y   = x[31] ? NEG_MAX : POS_MAX;
          r.ovf = 1'b1;
        end
      end
      default: begin
        r.y   = 32'd0;
        r.ovf = 1'b0;
        r.nx  = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ftoi_classify.sv
// Combinational operand classifier: range class, shift count and direction
// derived from the biased exponent.
module ftoi_classify
  import ftoi_seq_pkg::*;
(
  input  logic [7:0] exp_i,
  input  logic       frac_nz_i,
  output cls_e       cls_o,
  output logic [4:0] k_o,
  output logic       shl_o
);

  logic [4:0] up_s;
  logic [4:0] down_s;

  // Normal exponents lie within 23 of 150, so 5-bit wraparound on the low
  // exponent bits yields |E-150| exactly.
  assign up_s   = exp_i[4:0] - EXP_INT_BASE[4:0];
  assign down_s = EXP_INT_BASE[4:0] - exp_i[4:0];

  always_comb begin
    cls_o = CLS_ZERO;
    k_o   = 5'd0;
    shl_o = 1'b0;
    if (exp_i == 8'd0) begin
      cls_o = CLS_ZERO;
    end else if (exp_i < BIAS) begin
      cls_o = CLS_SMALL;
    end else if (exp_i < EXP_OVF) begin
      cls_o = CLS_NORMAL;
      if (exp_i > EXP_INT_BASE) begin
        shl_o = 1'b1;
        k_o   = up_s;
      end else begin
        shl_o = 1'b0;
        k_o   = down_s;
      end
    end else if ((exp_i == EXP_MAX) && frac_nz_i) begin
      cls_o = CLS_NAN;
    end else begin
      cls_o = CLS_OVF;
    end
  end

endmodule

// File: rtl/ftoi_seq.sv
// Sequential IEEE-754 single to int32 converter (truncate toward zero),
// shifting the mantissa one bit per cycle with valid/ready handshakes.
module ftoi_seq
  import ftoi_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] X,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [31:0] Y,
  output logic        OVF,
  output logic        NX,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  k_q, k_d;
  logic        shl_q, shl_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic [31:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        nx_q, nx_d;
  logic        ov_q, ov_d;

  cls_e        cls_s;
  logic [4:0]  k_s;
  logic        shl_s;
  logic        accept_s;
  logic        direct_s;
  logic [31:0] mant_s;
  logic [31:0] shifted_s;
  logic        sticky_n_s;
  result_t     special_s;

  ftoi_classify u_classify (
    .exp_i     (X[30:23]),
    .frac_nz_i (|X[22:0]),
    .cls_o     (cls_s),
    .k_o       (k_s),
    .shl_o     (shl_s)
  );

  assign IN_READY   = (state_q == ST_IDLE) & ~RST;
  assign accept_s   = IN_VALID & IN_READY;
  assign direct_s   = (cls_s != CLS_NORMAL) | (k_s == 5'd0);
  assign mant_s     = {8'd0, 1'b1, X[22:0]};
  assign shifted_s  = shl_q ? {mag_q[30:0], 1'b0} : {1'b0, mag_q[31:1]};
  assign sticky_n_s = sticky_q | (~shl_q & mag_q[0]);
  assign special_s  = special_result(cls_s, X);

  assign Y         = y_q;
  assign OVF       = ovf_q;
  assign NX        = nx_q;
  assign OUT_VALID = ov_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = direct_s ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (k_q == 5'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The final shift, sign application and result capture share one edge.
  always_comb begin
    mag_d    = mag_q;
    k_d      = k_q;
    shl_d    = shl_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    nx_d     = nx_q;
    ov_d     = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          mag_d    = mant_s;
          k_d      = k_s;
          shl_d    = shl_s;
          sign_d   = X[31];
          sticky_d = 1'b0;
          if (direct_s && (cls_s == CLS_NORMAL)) begin
            y_d   = apply_sign(X[31], mant_s);
            ovf_d = 1'b0;
            nx_d  = 1'b0;
            ov_d  = 1'b1;
          end else if (direct_s) begin
            y_d   = special_s.y;
            ovf_d = special_s.ovf;
            nx_d  = special_s.nx;
            ov_d  = 1'b1;
          end else begin
            ov_d = 1'b0;
          end
        end else begin
          ov_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        mag_d    = shifted_s;
        k_d      = k_q - 5'd1;
        sticky_d = sticky_n_s;
        if (k_q == 5'd1) begin
          y_d   = apply_sign(sign_q, shifted_s);
          ovf_d = 1'b0;
          nx_d  = sticky_n_s;
          ov_d  = 1'b1;
        end else begin
          ov_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          ov_d = 1'b0;
        end else begin
          ov_d = 1'b1;
        end
      end
      default: begin
        ov_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mag_q    <= 32'd0;
      k_q      <= 5'd0;
      shl_q    <= 1'b0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      y_q      <= 32'd0;
      ovf_q    <= 1'b0;
      nx_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      k_q      <= k_d;
      shl_q    <= shl_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      nx_q     <= nx_d;
      ov_q     <= ov_d;
    end
  end

endmodule
